delay_seq_checker: RTL
======================

// Module: delay_seq_checker
// PURPOSE
//  Synthesizable, multi-channel checker for the temporal relation "a ##[MIN_DLY:MAX_DLY] b".
//  Generalises the fixed "a ##2 b" bench assertion to configurable delay windows and channel counts.
//  Tracks overlapping attempts and reports per-attempt pass/fail pulses and saturating counts.
//  Sits beside the DUT in sim and emulation builds as an always-on protocol monitor.
// PARAMETERS
//  N_CH     4  number of independent channels (1..32)
//  MIN_DLY  2  earliest cycle after a at which b satisfies the attempt (1..MAX_DLY)
//  MAX_DLY  2  latest such cycle; attempt fails if no b by then (MIN_DLY..31)
//  CNT_W    16 width of each pass/fail counter (saturating)
// PORTS
//  clk         in   1          sampling clock; all inputs sampled on posedge
//  rst_n       in   1          asynchronous, active-low reset
//  en          in   1          1: a starts new attempts; 0: no new attempts, in-flight ones still resolve
//  clr         in   1          synchronous clear of counters and fail_sticky
//  a           in   N_CH       antecedent per channel
//  b           in   N_CH       consequent per channel
//  pass_pulse  out  N_CH       1-cycle pulse: >=1 attempt on the channel passed
//  fail_pulse  out  N_CH       1-cycle pulse: an attempt on the channel failed
//  pass_cnt    out  N_CH*CNT_W packed; channel i at [i*CNT_W +: CNT_W]
//  fail_cnt    out  N_CH*CNT_W packed, same layout
//  fail_sticky out  N_CH       set on fail, held until clr
//  any_fail    out  1          OR of fail_sticky
// BEHAVIOUR
//  - Reset (async assert, sync release): every output is 0, all pending attempts discarded.
//    Reset during in-flight attempts produces no fail for those attempts.
//  - Per channel, keep a pending vector age[1..MAX_DLY].
//    Bit k=1 means an attempt started k edges ago.
//    At each posedge: age[1] <= a & en; age[k+1] <= age[k] & ~hit[k].
//  - hit[k] = age[k] & b & (MIN_DLY <= k <= MAX_DLY).
//    All pending attempts inside the window complete on the first b, i.e. the same b may satisfy several attempts.
//  - miss = age[MAX_DLY] & ~b.
//  - Pulse latency: a at edge t, b at edge t+k -> pass_pulse high for the cycle after edge t+k.
//    Missing b at t+MAX_DLY -> fail_pulse after edge t+MAX_DLY.
//    Both pulses are registered.
//  - b before MIN_DLY does not complete an attempt.
//    The attempt stays pending and may pass or fail later.
//  - Counters:
//    - pass_cnt adds popcount(hit) per cycle; fail_cnt adds 1 on miss.
//    - Both saturate at 2**CNT_W-1; there is no wrap-around.
//    - Sum arithmetic is CNT_W+6 bits wide, then clamped.
//  - clr:
//    - Zeroes counters and fail_sticky on the next edge.
//    - clr wins over a simultaneous increment or fail.
//    - Pulses and pending attempts are unaffected.
//  - Simultaneous events:
//    - a and b high on the same edge: new attempt starts, and b also applies to older attempts.
//    - Pass and fail on the same cycle (different attempts): both pulses assert.
//  - en low: age[1] loads 0; existing pending bits keep shifting and resolving.
//  - Elaboration: $fatal if MIN_DLY<1, MIN_DLY>MAX_DLY, MAX_DLY>31 or N_CH outside 1..32.
// STRUCTURE
//  - Package delay_chk_pkg: MAX_DLY_LIMIT=31, MAX_CH=32, function sat_add(cnt,inc,w).
//  - Sub-module delay_chk_lane: one channel (pending vector, hit/miss, pulses, two counters, sticky).
//    Instantiated N_CH times in a generate loop.
//  - Top level holds only the lane loop, counter packing and the any_fail OR reduction.
// TESTING (clk period 2ns, N_CH=1 unless stated)
//  1 MIN=MAX=2; a=1 from edge 1; b rises at edge 3, low on edges 5, 6, high from edge 7.
//    -> pass after edges 3, 4, 7, 8...; fail after edges 5, 6; fail_cnt=2.
//  2 MIN=1, MAX=4; single a pulse, b high at edge +3 only.
//    -> exactly one pass_pulse 3 cycles later, no fail.
//  3 MIN=2, MAX=3; a every edge for 4 edges, b held 0.
//    -> 4 fail_pulses at edges +3..+6, fail_cnt=4, any_fail=1.
//  4 CNT_W=2; 5 consecutive fails.
//    -> fail_cnt saturates at 3.
//    -> clr coincident with a fail gives fail_cnt=0 and fail_sticky=0.
//  5 MIN=MAX=3; a pulse, rst_n low at edge +2, released before edge +3.
//    -> no pulses, all outputs 0.
//  6 N_CH=4; only channel 2 violates.
//    -> fail_sticky=4'b0100, other channels' counters are independent.

Source files
------------

// File: rtl/delay_chk_pkg.sv
// rtl/delay_chk_pkg.sv - shared limits and saturating add for the delay sequence checker
package delay_chk_pkg;

  localparam int MAX_DLY_LIMIT = 31;
  localparam int MAX_CH        = 32;
  localparam int SAT_W         = 64;

  // Clamp cnt+inc to the largest w-bit value; w must stay well below SAT_W.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] cnt,
                                               input logic [SAT_W-1:0] inc,
                                               input int               w);
    logic [SAT_W-1:0] lim;
    logic [SAT_W-1:0] sum;
    lim = (SAT_W'(1) << w) - SAT_W'(1);
    sum = cnt + inc;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/delay_chk_lane.sv
// rtl/delay_chk_lane.sv - one channel of a ##[MIN_DLY:MAX_DLY] b tracking, pulses, counters, sticky
module delay_chk_lane
  import delay_chk_pkg::*;
#(
  parameter int MIN_DLY = 2,
  parameter int MAX_DLY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_sticky
);

  logic [MAX_DLY:1] age;
  logic [MAX_DLY:1] age_nxt;
  logic [MAX_DLY:1] hit;
  logic             miss;
  logic [5:0]       hit_cnt;
  logic [CNT_W-1:0] pass_nxt;
  logic [CNT_W-1:0] fail_nxt;

  // One b retires every pending attempt whose age lies inside the window.
  for (genvar k = 1; k <= MAX_DLY; k++) begin : g_hit
    assign hit[k] = (k >= MIN_DLY) ? (age[k] & b) : 1'b0;
  end

  assign age_nxt[1] = a & en;
  for (genvar k = 1; k < MAX_DLY; k++) begin : g_shift
    assign age_nxt[k+1] = age[k] & ~hit[k];
  end

  assign miss     = age[MAX_DLY] & ~b;
  assign hit_cnt  = 6'($countones(hit));
  assign pass_nxt = CNT_W'(sat_add(SAT_W'(pass_cnt), SAT_W'(hit_cnt), CNT_W));
  assign fail_nxt = CNT_W'(sat_add(SAT_W'(fail_cnt), SAT_W'(miss), CNT_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age         <= '0;
      pass_pulse  <= 1'b0;
      fail_pulse  <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      fail_sticky <= 1'b0;
    end else begin
      age        <= age_nxt;
      pass_pulse <= |hit;
      fail_pulse <= miss;
      if (clr) begin
        pass_cnt    <= '0;
        fail_cnt    <= '0;
        fail_sticky <= 1'b0;
      end else begin
        pass_cnt    <= pass_nxt;
        fail_cnt    <= fail_nxt;
        fail_sticky <= fail_sticky | miss;
      end
    end
  end

endmodule

// File: rtl/delay_seq_checker.sv
// rtl/delay_seq_checker.sv - multi-channel a ##[MIN_DLY:MAX_DLY] b protocol monitor
module delay_seq_checker
  import delay_chk_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int MIN_DLY = 2,
  parameter int MAX_DLY = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [N_CH-1:0]       a,
  input  logic [N_CH-1:0]       b,
  output logic [N_CH-1:0]       pass_pulse,
  output logic [N_CH-1:0]       fail_pulse,
  output logic [N_CH*CNT_W-1:0] pass_cnt,
  output logic [N_CH*CNT_W-1:0] fail_cnt,
  output logic [N_CH-1:0]       fail_sticky,
  output logic                  any_fail
);

  if (MIN_DLY < 1 || MIN_DLY > MAX_DLY || MAX_DLY > MAX_DLY_LIMIT ||
      N_CH < 1 || N_CH > MAX_CH) begin : g_bad_param
    $fatal(1, "delay_seq_checker: illegal N_CH/MIN_DLY/MAX_DLY");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    delay_chk_lane #(
      .MIN_DLY(MIN_DLY),
      .MAX_DLY(MAX_DLY),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .clr        (clr),
      .a          (a[i]),
      .b          (b[i]),
      .pass_pulse (pass_pulse[i]),
      .fail_pulse (fail_pulse[i]),
      .pass_cnt   (pass_cnt[i*CNT_W +: CNT_W]),
      .fail_cnt   (fail_cnt[i*CNT_W +: CNT_W]),
      .fail_sticky(fail_sticky[i])
    );
  end

  assign any_fail = |fail_sticky;

endmodule
